// File: rtl/signext_arbiter.sv
// Round-robin arbiter that shares one registered 8->16 sign-extend unit between two requesters.
// The block post-processes the extender output by mode and returns it, tagged with the requester id.
module signext_arbiter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  output logic [IN_W-1:0]  ext_in,
  input  logic [OUT_W-1:0] ext_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_id,
  output logic             res_err
);
  localparam int NREQ = 2;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_SHL1 = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, DONE} state_t;
  state_t state_reg, state_next;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][IN_W-1:0] req_data;
  logic [NREQ-1:0][1:0]      req_mode;
  logic [NREQ-1:0]           req_ready;
  logic                      grant_id;
  logic                      accept;

  logic                      rr_prio_reg;
  logic [1:0]                mode_reg;
  logic                      id_reg;
  logic [IN_W-1:0]           ext_in_reg;
  logic                      res_valid_reg;
  logic [OUT_W-1:0]          res_data_reg;
  logic [OUT_W-1:0]          res_data_next;
  logic                      res_id_reg;
  logic                      res_err_reg;
  logic                      res_err_next;

  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};
  assign req_mode  = {req1_mode, req0_mode};

  // A lone requester always wins; rr_prio only breaks ties.
  always_comb begin
    grant_id = rr_prio_reg;
    if (req_valid == 2'b01) begin
      grant_id = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && !rst && req_valid[gi] && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |req_ready;

  always_comb begin
    res_data_next = ext_out;
    res_err_next  = 1'b0;
    case (mode_reg)
      MODE_ZEXT: res_data_next = {{(OUT_W-IN_W){1'b0}}, ext_out[IN_W-1:0]};
      MODE_SHL1: res_data_next = {ext_out[OUT_W-2:0], 1'b0};
      MODE_ILL:  res_err_next  = 1'b1;
      default:   res_data_next = ext_out;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = SAMPLE;
      SAMPLE:  state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_prio_reg   <= 1'b0;
      mode_reg      <= 2'b00;
      id_reg        <= 1'b0;
      ext_in_reg    <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= 1'b0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ext_in_reg  <= req_data[grant_id];
        mode_reg    <= req_mode[grant_id];
        id_reg      <= grant_id;
        rr_prio_reg <= ~grant_id;
      end
      if (state_reg == SAMPLE) begin
        res_data_reg  <= res_data_next;
        res_id_reg    <= id_reg;
        res_err_reg   <= res_err_next;
        res_valid_reg <= 1'b1;
      end
      if (state_reg == DONE && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign ext_in    = ext_in_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_err   = res_err_reg;

endmodule
